// File: rtl/wb_addr_router_pkg.sv
// Shared platform map for the Wishbone address router: slave indices, address windows,
// router limits and the router state type.
package wb_addr_router_pkg;

  localparam int NUM_SLAVES = 5;

  localparam int DMEM_SLAVE_INDEX   = 0;
  localparam int MTIMER_SLAVE_INDEX = 1;
  localparam int LED_SLAVE_INDEX    = 2;
  localparam int WBUART_SLAVE_INDEX = 3;
  localparam int HDMI_SLAVE_INDEX   = 4;

  localparam int SLAVE_INDICES [NUM_SLAVES] = '{
    DMEM_SLAVE_INDEX, MTIMER_SLAVE_INDEX, LED_SLAVE_INDEX, WBUART_SLAVE_INDEX, HDMI_SLAVE_INDEX
  };

  localparam int ROUTER_MAX_OUTSTANDING = 4;
  localparam int ROUTER_TIMEOUT_CYCLES  = 255;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_DECERR
  } router_state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [NUM_SLAVES-1:0][31:0] platform_start();
    logic [NUM_SLAVES-1:0][31:0] r;
    r = '0;
    r[DMEM_SLAVE_INDEX]   = 32'h9000_0000;
    r[MTIMER_SLAVE_INDEX] = 32'hA000_0000;
    r[LED_SLAVE_INDEX]    = 32'hA000_0010;
    r[WBUART_SLAVE_INDEX] = 32'hA000_0020;
    r[HDMI_SLAVE_INDEX]   = 32'hB000_0000;
    return r;
  endfunction

  function automatic logic [NUM_SLAVES-1:0][31:0] platform_mask();
    logic [NUM_SLAVES-1:0][31:0] r;
    r = '0;
    r[DMEM_SLAVE_INDEX]   = 32'hF000_0000;
    r[MTIMER_SLAVE_INDEX] = 32'hFFFF_FFF0;
    r[LED_SLAVE_INDEX]    = 32'hFFFF_FFF0;
    r[WBUART_SLAVE_INDEX] = 32'hFFFF_FFF0;
    r[HDMI_SLAVE_INDEX]   = 32'hF000_0000;
    return r;
  endfunction

  localparam logic [NUM_SLAVES-1:0][31:0] START_ADDRESS = platform_start();
  localparam logic [NUM_SLAVES-1:0][31:0] MASK          = platform_mask();

  // A slave index must be in range and used by exactly one slave.
  function automatic bit indices_unique();
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (SLAVE_INDICES[i] < 0 || SLAVE_INDICES[i] >= NUM_SLAVES) return 1'b0;
      for (int j = i + 1; j < NUM_SLAVES; j++)
        if (SLAVE_INDICES[i] == SLAVE_INDICES[j]) return 1'b0;
    end
    return 1'b1;
  endfunction

endpackage

// File: rtl/wb_addr_decoder.sv
// Combinational address decoder: reports whether any slave window matches and which
// slave wins, the lowest index taking priority.
module wb_addr_decoder #(
  parameter int NUM_SLAVES = wb_addr_router_pkg::NUM_SLAVES,
  parameter logic [NUM_SLAVES-1:0][31:0] START_ADDRESS = wb_addr_router_pkg::START_ADDRESS,
  parameter logic [NUM_SLAVES-1:0][31:0] MASK = wb_addr_router_pkg::MASK
) (
  input  logic [31:0] adr,
  output logic        hit,
  output logic [wb_addr_router_pkg::idx_width(NUM_SLAVES)-1:0] idx
);
  import wb_addr_router_pkg::*;

  localparam int IDX_W = idx_width(NUM_SLAVES);

  // Scan from the top down so the lowest matching index is the one left standing.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
      if ((adr & MASK[k]) == START_ADDRESS[k]) begin
        hit = 1'b1;
        idx = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/wb_addr_router.sv
// Pipelined Wishbone 1-to-N router: locks onto one slave while requests are outstanding,
// answers decode misses with a one-cycle error and aborts silent slaves after a timeout.
module wb_addr_router #(
  parameter int NUM_SLAVES = wb_addr_router_pkg::NUM_SLAVES,
  parameter logic [NUM_SLAVES-1:0][31:0] START_ADDRESS = wb_addr_router_pkg::START_ADDRESS,
  parameter logic [NUM_SLAVES-1:0][31:0] MASK = wb_addr_router_pkg::MASK,
  parameter int MAX_OUTSTANDING = wb_addr_router_pkg::ROUTER_MAX_OUTSTANDING,
  parameter int TIMEOUT_CYCLES  = wb_addr_router_pkg::ROUTER_TIMEOUT_CYCLES
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        wbm_cyc_i,
  input  logic                        wbm_stb_i,
  input  logic                        wbm_we_i,
  input  logic [31:0]                 wbm_adr_i,
  input  logic [31:0]                 wbm_dat_i,
  input  logic [3:0]                  wbm_sel_i,
  output logic                        wbm_stall_o,
  output logic                        wbm_ack_o,
  output logic                        wbm_err_o,
  output logic [31:0]                 wbm_dat_o,
  output logic [NUM_SLAVES-1:0]       wbs_cyc_o,
  output logic [NUM_SLAVES-1:0]       wbs_stb_o,
  output logic [NUM_SLAVES-1:0]       wbs_we_o,
  output logic [NUM_SLAVES-1:0][31:0] wbs_adr_o,
  output logic [NUM_SLAVES-1:0][31:0] wbs_dat_o,
  output logic [NUM_SLAVES-1:0][3:0]  wbs_sel_o,
  input  logic [NUM_SLAVES-1:0]       wbs_stall_i,
  input  logic [NUM_SLAVES-1:0]       wbs_ack_i,
  input  logic [NUM_SLAVES-1:0]       wbs_err_i,
  input  logic [NUM_SLAVES-1:0][31:0] wbs_dat_i
);
  import wb_addr_router_pkg::*;

  localparam int IDX_W = idx_width(NUM_SLAVES);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  function automatic bit map_overlaps();
    for (int i = 0; i < NUM_SLAVES; i++)
      for (int j = i + 1; j < NUM_SLAVES; j++)
        if (((START_ADDRESS[i] ^ START_ADDRESS[j]) & MASK[i] & MASK[j]) == 32'h0) return 1'b1;
    return 1'b0;
  endfunction

  if (!indices_unique()) begin : g_bad_indices
    $error("wb_addr_router: duplicate or out-of-range slave indices in platform map");
  end
  if (map_overlaps()) begin : g_bad_map
    $error("wb_addr_router: overlapping slave address regions");
  end

  router_state_e    state_q, state_d;
  logic [IDX_W-1:0] lk_q, lk_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;

  logic             dec_hit;
  logic [IDX_W-1:0] dec_idx;
  logic             route_en, route_stb;
  logic [IDX_W-1:0] route_idx;
  logic             accept, resp, timeout;

  wb_addr_decoder #(
    .NUM_SLAVES(NUM_SLAVES),
    .START_ADDRESS(START_ADDRESS),
    .MASK(MASK)
  ) u_decoder (
    .adr(wbm_adr_i),
    .hit(dec_hit),
    .idx(dec_idx)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      lk_q    <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      lk_q    <= lk_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  // The timeout fires on the cycle the wait count would reach TIMEOUT_CYCLES; that cycle
  // also cuts the slave's cycle so it cannot answer into the next transfer.
  always_comb begin
    state_d     = state_q;
    lk_d        = lk_q;
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;
    route_en    = 1'b0;
    route_stb   = 1'b0;
    route_idx   = lk_q;
    wbm_stall_o = 1'b0;
    wbm_ack_o   = 1'b0;
    wbm_err_o   = 1'b0;
    wbm_dat_o   = '0;
    timeout     = 1'b0;
    resp        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (dec_hit) begin
          route_en    = 1'b1;
          route_idx   = dec_idx;
          route_stb   = wbm_stb_i;
          wbm_stall_o = wbs_stall_i[dec_idx];
        end
      end
      ST_ACTIVE: begin
        timeout = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
        if (timeout) begin
          wbm_err_o   = 1'b1;
          wbm_stall_o = 1'b1;
        end else begin
          route_en  = 1'b1;
          resp      = wbm_cyc_i & (wbs_ack_i[lk_q] | wbs_err_i[lk_q]);
          wbm_ack_o = wbm_cyc_i & wbs_ack_i[lk_q];
          wbm_err_o = wbm_cyc_i & wbs_err_i[lk_q];
          if (dec_hit && dec_idx == lk_q && cnt_q < CNT_W'(MAX_OUTSTANDING)) begin
            route_stb   = wbm_stb_i;
            wbm_stall_o = wbs_stall_i[lk_q];
          end else begin
            wbm_stall_o = 1'b1;
          end
        end
      end
      ST_DECERR: begin
        wbm_err_o   = 1'b1;
        wbm_stall_o = 1'b1;
      end
      default: ;
    endcase

    accept = wbm_cyc_i & wbm_stb_i & ~wbm_stall_o;
    if (wbm_ack_o) wbm_dat_o = wbs_dat_i[lk_q];

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (dec_hit) begin
            state_d = ST_ACTIVE;
            lk_d    = dec_idx;
            cnt_d   = CNT_W'(1);
            tmo_d   = '0;
          end else begin
            state_d = ST_DECERR;
          end
        end
      end
      ST_ACTIVE: begin
        if (!wbm_cyc_i || timeout) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          tmo_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(accept) - CNT_W'(resp);
          tmo_d = (accept || resp) ? '0 : tmo_q + TMO_W'(1);
          if (cnt_d == '0) state_d = ST_IDLE;
        end
      end
      ST_DECERR: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    for (int k = 0; k < NUM_SLAVES; k++) begin
      wbs_adr_o[k] = wbm_adr_i;
      wbs_dat_o[k] = wbm_dat_i;
      wbs_sel_o[k] = wbm_sel_i;
      wbs_cyc_o[k] = wbm_cyc_i & route_en & (route_idx == IDX_W'(k));
      wbs_stb_o[k] = wbs_cyc_o[k] & route_stb;
      wbs_we_o[k]  = wbs_cyc_o[k] & wbm_we_i;
    end
  end

endmodule

// File: tb/tb_wb_addr_router.sv
// Self-checking bench for wb_addr_router: scenario tasks plus a scoreboard of the
// requests each slave should see forwarded.
module tb_wb_addr_router;

  localparam int NS     = 5;
  localparam int DMEM   = 0;
  localparam int MTIMER = 1;
  localparam int LED    = 2;
  localparam int UART   = 3;

  logic clk_i = 1'b0;
  logic rst_i;
  logic wbm_cyc_i, wbm_stb_i, wbm_we_i;
  logic [31:0] wbm_adr_i, wbm_dat_i;
  logic [3:0] wbm_sel_i;
  logic wbm_stall_o, wbm_ack_o, wbm_err_o;
  logic [31:0] wbm_dat_o;
  logic [NS-1:0] wbs_cyc_o, wbs_stb_o, wbs_we_o;
  logic [NS-1:0][31:0] wbs_adr_o, wbs_dat_o;
  logic [NS-1:0][3:0] wbs_sel_o;
  logic [NS-1:0] wbs_stall_i, wbs_ack_i, wbs_err_i;
  logic [NS-1:0][31:0] wbs_dat_i;

  typedef struct packed {
    logic [2:0]  idx;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } slave_req_t;

  slave_req_t sb_q[$];
  slave_req_t mon_exp;
  logic [NS-1:0] mon_stb;
  int checks_total = 0;
  int checks_passed = 0;

  wb_addr_router dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .wbm_cyc_i(wbm_cyc_i), .wbm_stb_i(wbm_stb_i), .wbm_we_i(wbm_we_i),
    .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_sel_i(wbm_sel_i),
    .wbm_stall_o(wbm_stall_o), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o),
    .wbm_dat_o(wbm_dat_o),
    .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o), .wbs_we_o(wbs_we_o),
    .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o),
    .wbs_stall_i(wbs_stall_i), .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i),
    .wbs_dat_i(wbs_dat_i)
  );

  always #5 clk_i = ~clk_i;

  // Every slave-side acceptance must match the oldest request the bench expected to be forwarded.
  always @(negedge clk_i) begin
    #2;
    if (!rst_i && (wbs_stb_o & wbs_cyc_o & ~wbs_stall_i) != '0) begin
      checks_total++;
      if (sb_q.size() == 0) begin
        $display("[TB] FAIL sb_unexpected: strobe %b with no expected request", wbs_stb_o);
      end else begin
        mon_exp = sb_q.pop_front();
        mon_stb = '0;
        mon_stb[mon_exp.idx] = 1'b1;
        if (wbs_stb_o !== mon_stb || wbs_adr_o[mon_exp.idx] !== mon_exp.adr ||
            wbs_dat_o[mon_exp.idx] !== mon_exp.dat || wbs_we_o[mon_exp.idx] !== mon_exp.we ||
            wbs_sel_o[mon_exp.idx] !== 4'hF)
          $display("[TB] FAIL sb_forward: stb=%b adr=%h dat=%h we=%b, required stb=%b adr=%h dat=%h we=%b",
                   wbs_stb_o, wbs_adr_o[mon_exp.idx], wbs_dat_o[mon_exp.idx], wbs_we_o[mon_exp.idx],
                   mon_stb, mon_exp.adr, mon_exp.dat, mon_exp.we);
        else
          checks_passed++;
      end
    end
  end

  task automatic bus_idle();
    wbm_cyc_i = 1'b0; wbm_stb_i = 1'b0; wbm_we_i = 1'b0;
    wbm_adr_i = '0; wbm_dat_i = '0; wbm_sel_i = '0;
    wbs_stall_i = '0; wbs_ack_i = '0; wbs_err_i = '0;
  endtask

  task automatic drive_master(input logic cyc, input logic stb, input logic we,
                              input logic [31:0] adr, input logic [31:0] dat);
    wbm_cyc_i = cyc; wbm_stb_i = stb; wbm_we_i = we;
    wbm_adr_i = adr; wbm_dat_i = dat; wbm_sel_i = 4'hF;
  endtask

  task automatic expect_fwd(input int idx, input logic we, input logic [31:0] adr, input logic [31:0] dat);
    slave_req_t r;
    r.idx = 3'(idx); r.we = we; r.adr = adr; r.dat = dat;
    sb_q.push_back(r);
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    bus_idle();
    wbs_dat_i = '0;
    repeat (2) @(negedge clk_i);
    #1;
    checks_total++;
    if ({wbm_stall_o, wbm_ack_o, wbm_err_o} !== 3'b000)
      $display("[TB] FAIL reset_ctrl: stall/ack/err=%b required 000", {wbm_stall_o, wbm_ack_o, wbm_err_o});
    else checks_passed++;
    checks_total++;
    if (wbm_dat_o !== 32'h0) $display("[TB] FAIL reset_dat: got %h required 0", wbm_dat_o);
    else checks_passed++;
    checks_total++;
    if ({wbs_cyc_o, wbs_stb_o, wbs_we_o} !== 15'h0)
      $display("[TB] FAIL reset_slave: cyc=%b stb=%b we=%b required all 0", wbs_cyc_o, wbs_stb_o, wbs_we_o);
    else checks_passed++;
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    expect_fwd(DMEM, 1'b0, 32'h9000_0008, 32'h0);
    drive_master(1'b1, 1'b1, 1'b0, 32'h9000_0008, 32'h0);
    #1;
    checks_total++;
    if (wbm_stall_o !== 1'b0) $display("[TB] FAIL reset_pre_req_stall: got %b required 0", wbm_stall_o);
    else checks_passed++;
    @(negedge clk_i);
    drive_master(1'b1, 1'b0, 1'b0, 32'h9000_0008, 32'h0);
    #1 rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    wbs_dat_i[DMEM] = 32'h5555_AAAA;
    wbs_ack_i[DMEM] = 1'b1;
    #1;
    checks_total++;
    if (wbm_ack_o !== 1'b0 || wbm_dat_o !== 32'h0)
      $display("[TB] FAIL reset_discard: ack=%b dat=%h required ack 0 dat 0", wbm_ack_o, wbm_dat_o);
    else checks_passed++;
    @(negedge clk_i);
    bus_idle();
  endtask

  task automatic test_led_write();
    @(negedge clk_i);
    expect_fwd(LED, 1'b1, 32'hA000_0010, 32'h0000_00A5);
    drive_master(1'b1, 1'b1, 1'b1, 32'hA000_0010, 32'h0000_00A5);
    wbs_dat_i[LED] = 32'hDEAD_BEEF;
    #1;
    checks_total++;
    if (wbs_stb_o !== 5'b00100 || wbs_we_o !== 5'b00100 || wbm_stall_o !== 1'b0)
      $display("[TB] FAIL led_fwd: stb=%b we=%b stall=%b required 00100 00100 0", wbs_stb_o, wbs_we_o, wbm_stall_o);
    else checks_passed++;
    checks_total++;
    if (wbm_dat_o !== 32'h0) $display("[TB] FAIL led_dat_no_ack: got %h required 0", wbm_dat_o);
    else checks_passed++;
    @(negedge clk_i);
    drive_master(1'b1, 1'b0, 1'b1, 32'hA000_0010, 32'h0000_00A5);
    wbs_ack_i[LED] = 1'b1;
    #1;
    checks_total++;
    if (wbm_ack_o !== 1'b1 || wbm_err_o !== 1'b0 || wbm_dat_o !== 32'hDEAD_BEEF)
      $display("[TB] FAIL led_ack: ack=%b err=%b dat=%h required 1 0 deadbeef", wbm_ack_o, wbm_err_o, wbm_dat_o);
    else checks_passed++;
    @(negedge clk_i);
    wbs_ack_i = '0;
    drive_master(1'b1, 1'b0, 1'b0, 32'h0000_1000, 32'h0);
    #1;
    checks_total++;
    if (wbs_cyc_o !== 5'b00000) $display("[TB] FAIL led_idle: cyc=%b required 00000", wbs_cyc_o);
    else checks_passed++;
    @(negedge clk_i);
    bus_idle();
  endtask

  task automatic test_back_to_back();
    @(negedge clk_i);
    expect_fwd(DMEM, 1'b0, 32'h9000_0004, 32'h0);
    drive_master(1'b1, 1'b1, 1'b0, 32'h9000_0004, 32'h0);
    #1;
    checks_total++;
    if (wbs_stb_o !== 5'b00001 || wbm_stall_o !== 1'b0)
      $display("[TB] FAIL b2b_first: stb=%b stall=%b required 00001 0", wbs_stb_o, wbm_stall_o);
    else checks_passed++;
    @(negedge clk_i);
    drive_master(1'b1, 1'b1, 1'b0, 32'hA000_0020, 32'h0);
    #1;
    checks_total++;
    if (wbm_stall_o !== 1'b1 || wbs_stb_o !== 5'b00000)
      $display("[TB] FAIL b2b_stalled: stall=%b stb=%b required 1 00000", wbm_stall_o, wbs_stb_o);
    else checks_passed++;
    @(negedge clk_i);
    wbs_dat_i[DMEM] = 32'h1234_5678;
    wbs_ack_i[DMEM] = 1'b1;
    #1;
    checks_total++;
    if (wbm_ack_o !== 1'b1 || wbm_dat_o !== 32'h1234_5678 || wbm_stall_o !== 1'b1)
      $display("[TB] FAIL b2b_dmem_ack: ack=%b dat=%h stall=%b required 1 12345678 1", wbm_ack_o, wbm_dat_o, wbm_stall_o);
    else checks_passed++;
    @(negedge clk_i);
    wbs_ack_i = '0;
    expect_fwd(UART, 1'b0, 32'hA000_0020, 32'h0);
    #1;
    checks_total++;
    if (wbs_stb_o !== 5'b01000 || wbm_stall_o !== 1'b0)
      $display("[TB] FAIL b2b_uart_fwd: stb=%b stall=%b required 01000 0", wbs_stb_o, wbm_stall_o);
    else checks_passed++;
    @(negedge clk_i);
    drive_master(1'b1, 1'b0, 1'b0, 32'hA000_0020, 32'h0);
    wbs_dat_i[UART] = 32'hCAFE_0001;
    wbs_ack_i[UART] = 1'b1;
    #1;
    checks_total++;
    if (wbm_ack_o !== 1'b1 || wbm_dat_o !== 32'hCAFE_0001)
      $display("[TB] FAIL b2b_uart_ack: ack=%b dat=%h required 1 cafe0001", wbm_ack_o, wbm_dat_o);
    else checks_passed++;
    @(negedge clk_i);
    bus_idle();
  endtask

  task automatic test_decode_miss();
    @(negedge clk_i);
    drive_master(1'b1, 1'b1, 1'b0, 32'h0000_1000, 32'h0);
    #1;
    checks_total++;
    if (wbm_stall_o !== 1'b0 || wbs_stb_o !== 5'b0 || wbs_cyc_o !== 5'b0 || wbm_err_o !== 1'b0)
      $display("[TB] FAIL miss_accept: stall=%b stb=%b cyc=%b err=%b required 0 0 0 0",
               wbm_stall_o, wbs_stb_o, wbs_cyc_o, wbm_err_o);
    else checks_passed++;
    @(negedge clk_i);
    drive_master(1'b1, 1'b0, 1'b0, 32'h0000_1000, 32'h0);
    #1;
    checks_total++;
    if (wbm_err_o !== 1'b1 || wbm_stall_o !== 1'b1)
      $display("[TB] FAIL miss_err: err=%b stall=%b required 1 1", wbm_err_o, wbm_stall_o);
    else checks_passed++;
    @(negedge clk_i);
    #1;
    checks_total++;
    if (wbm_err_o !== 1'b0) $display("[TB] FAIL miss_err_once: err=%b required 0", wbm_err_o);
    else checks_passed++;
    @(negedge clk_i);
    bus_idle();
  endtask

  task automatic test_max_outstanding();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      expect_fwd(DMEM, 1'b0, 32'h9000_0000 + 32'(4 * i), 32'h0);
      drive_master(1'b1, 1'b1, 1'b0, 32'h9000_0000 + 32'(4 * i), 32'h0);
      #1;
      checks_total++;
      if (wbm_stall_o !== 1'b0) $display("[TB] FAIL max_accept_%0d: stall=%b required 0", i, wbm_stall_o);
      else checks_passed++;
    end
    @(negedge clk_i);
    drive_master(1'b1, 1'b1, 1'b0, 32'h9000_0010, 32'h0);
    #1;
    checks_total++;
    if (wbm_stall_o !== 1'b1 || wbs_stb_o !== 5'b0)
      $display("[TB] FAIL max_fifth_stall: stall=%b stb=%b required 1 00000", wbm_stall_o, wbs_stb_o);
    else checks_passed++;
    @(negedge clk_i);
    wbs_dat_i[DMEM] = 32'h0000_0001;
    wbs_ack_i[DMEM] = 1'b1;
    #1;
    checks_total++;
    if (wbm_ack_o !== 1'b1 || wbm_stall_o !== 1'b1)
      $display("[TB] FAIL max_ack: ack=%b stall=%b required 1 1", wbm_ack_o, wbm_stall_o);
    else checks_passed++;
    @(negedge clk_i);
    wbs_ack_i = '0;
    expect_fwd(DMEM, 1'b0, 32'h9000_0010, 32'h0);
    #1;
    checks_total++;
    if (wbm_stall_o !== 1'b0) $display("[TB] FAIL max_fifth_accept: stall=%b required 0", wbm_stall_o);
    else checks_passed++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      drive_master(1'b1, 1'b0, 1'b0, 32'h9000_0010, 32'h0);
      wbs_ack_i[DMEM] = 1'b1;
      #1;
      checks_total++;
      if (wbm_ack_o !== 1'b1) $display("[TB] FAIL max_drain_%0d: ack=%b required 1", i, wbm_ack_o);
      else checks_passed++;
    end
    @(negedge clk_i);
    wbs_ack_i = '0;
    drive_master(1'b1, 1'b0, 1'b0, 32'h0000_1000, 32'h0);
    #1;
    checks_total++;
    if (wbs_cyc_o !== 5'b0) $display("[TB] FAIL max_idle: cyc=%b required 00000", wbs_cyc_o);
    else checks_passed++;
    @(negedge clk_i);
    bus_idle();
  endtask

  task automatic test_timeout();
    int wait_cycles;
    bit fired;
    wait_cycles = 0;
    fired = 1'b0;
    @(negedge clk_i);
    expect_fwd(MTIMER, 1'b1, 32'hA000_0000, 32'h0000_0011);
    drive_master(1'b1, 1'b1, 1'b1, 32'hA000_0000, 32'h0000_0011);
    #1;
    checks_total++;
    if (wbm_stall_o !== 1'b0) $display("[TB] FAIL tmo_accept: stall=%b required 0", wbm_stall_o);
    else checks_passed++;
    while (!fired && wait_cycles < 400) begin
      @(negedge clk_i);
      drive_master(1'b1, 1'b0, 1'b1, 32'hA000_0000, 32'h0000_0011);
      wait_cycles++;
      #1;
      if (wbm_err_o === 1'b1) fired = 1'b1;
    end
    checks_total++;
    if (!fired || wait_cycles != 255)
      $display("[TB] FAIL tmo_latency: err after %0d cycles (fired=%0d) required 255", wait_cycles, fired);
    else checks_passed++;
    checks_total++;
    if (wbs_cyc_o !== 5'b0) $display("[TB] FAIL tmo_cyc_cut: cyc=%b required 00000", wbs_cyc_o);
    else checks_passed++;
    @(negedge clk_i);
    wbs_ack_i[MTIMER] = 1'b1;
    #1;
    checks_total++;
    if (wbm_ack_o !== 1'b0 || wbm_err_o !== 1'b0)
      $display("[TB] FAIL tmo_idle: ack=%b err=%b required 0 0", wbm_ack_o, wbm_err_o);
    else checks_passed++;
    @(negedge clk_i);
    bus_idle();
  endtask

  task automatic test_abort();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      expect_fwd(DMEM, 1'b0, 32'h9000_0100 + 32'(4 * i), 32'h0);
      drive_master(1'b1, 1'b1, 1'b0, 32'h9000_0100 + 32'(4 * i), 32'h0);
    end
    @(negedge clk_i);
    drive_master(1'b0, 1'b0, 1'b0, 32'h9000_0104, 32'h0);
    #1;
    checks_total++;
    if (wbs_cyc_o !== 5'b0) $display("[TB] FAIL abort_cyc: cyc=%b required 00000", wbs_cyc_o);
    else checks_passed++;
    @(negedge clk_i);
    wbs_dat_i[DMEM] = 32'h7777_0000;
    wbs_ack_i[DMEM] = 1'b1;
    #1;
    checks_total++;
    if (wbm_ack_o !== 1'b0) $display("[TB] FAIL abort_late_ack: ack=%b required 0", wbm_ack_o);
    else checks_passed++;
    @(negedge clk_i);
    wbs_ack_i = '0;
    expect_fwd(LED, 1'b1, 32'hA000_0014, 32'h0000_005A);
    drive_master(1'b1, 1'b1, 1'b1, 32'hA000_0014, 32'h0000_005A);
    #1;
    checks_total++;
    if (wbs_stb_o !== 5'b00100 || wbm_stall_o !== 1'b0)
      $display("[TB] FAIL abort_next_fwd: stb=%b stall=%b required 00100 0", wbs_stb_o, wbm_stall_o);
    else checks_passed++;
    @(negedge clk_i);
    drive_master(1'b1, 1'b0, 1'b1, 32'hA000_0014, 32'h0000_005A);
    wbs_ack_i[LED] = 1'b1;
    #1;
    checks_total++;
    if (wbm_ack_o !== 1'b1) $display("[TB] FAIL abort_next_ack: ack=%b required 1", wbm_ack_o);
    else checks_passed++;
    @(negedge clk_i);
    bus_idle();
  endtask

  initial begin
    test_reset();
    test_led_write();
    test_back_to_back();
    test_decode_miss();
    test_max_outstanding();
    test_timeout();
    test_abort();
    repeat (2) @(negedge clk_i);
    checks_total++;
    if (sb_q.size() != 0) $display("[TB] FAIL sb_leftover: %0d requests never forwarded, required 0", sb_q.size());
    else checks_passed++;
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
